// File: rtl/spi_fpga_burst_feeder_if.sv
// spi_fpga_burst_feeder_if
// Bundles the feeder's push side, error clear and SPI master handshake.
//   slave  : the feeder itself (consumes IN_*, drives OUT_*)
//   master : whatever drives the feeder (host logic, SPI master glue, bench)
// Signals:
//   IN_PUSH / IN_PUSH_DATA            word enqueue strobe and data
//   IN_CLEAR_ERROR                    clears sticky OUT_TIMEOUT
//   IN_CS                             master chip select, active-low
//   IN_MASTER_ACTION_DONE             master completion flag
//   IN_MASTER_RECEIVE_DATA            word received by master
//   OUT_LAUNCH / OUT_MASTER_DATA      launch request and word to send
//   OUT_RX_DATA / OUT_RX_VALID        captured receive word and 1-cycle strobe
//   OUT_FULL / OUT_EMPTY              FIFO status
//   OUT_BUSY                          feeder not idle
//   OUT_TIMEOUT                       sticky watchdog error
interface spi_fpga_burst_feeder_if #(
  parameter int PACK_LENGTH = 8
);
  logic                   IN_PUSH;
  logic [PACK_LENGTH-1:0] IN_PUSH_DATA;
  logic                   IN_CLEAR_ERROR;
  logic                   IN_CS;
  logic                   IN_MASTER_ACTION_DONE;
  logic [PACK_LENGTH-1:0] IN_MASTER_RECEIVE_DATA;
  logic                   OUT_LAUNCH;
  logic [PACK_LENGTH-1:0] OUT_MASTER_DATA;
  logic [PACK_LENGTH-1:0] OUT_RX_DATA;
  logic                   OUT_RX_VALID;
  logic                   OUT_FULL;
  logic                   OUT_EMPTY;
  logic                   OUT_BUSY;
  logic                   OUT_TIMEOUT;

  modport slave (
    input  IN_PUSH, IN_PUSH_DATA, IN_CLEAR_ERROR, IN_CS,
           IN_MASTER_ACTION_DONE, IN_MASTER_RECEIVE_DATA,
    output OUT_LAUNCH, OUT_MASTER_DATA, OUT_RX_DATA, OUT_RX_VALID,
           OUT_FULL, OUT_EMPTY, OUT_BUSY, OUT_TIMEOUT
  );

  modport master (
    output IN_PUSH, IN_PUSH_DATA, IN_CLEAR_ERROR, IN_CS,
           IN_MASTER_ACTION_DONE, IN_MASTER_RECEIVE_DATA,
    input  OUT_LAUNCH, OUT_MASTER_DATA, OUT_RX_DATA, OUT_RX_VALID,
           OUT_FULL, OUT_EMPTY, OUT_BUSY, OUT_TIMEOUT
  );
endinterface

// File: rtl/spi_fpga_burst_feeder.sv
// spi_fpga_burst_feeder
// Queues transmit words in a small FIFO and feeds them one at a time to an
// SPI_FPGA_MASTER: presents the word, raises OUT_LAUNCH until CS has been
// low for LAUNCH_HOLD_CLKS clocks, waits for the master's done edge and
// captures the received word. A per-word watchdog aborts stuck transfers
// and raises a sticky OUT_TIMEOUT that blocks new transfers until cleared.
// Ports:
//   IN_CLOCK    system clock, rising edge
//   IN_RESET_N  asynchronous active-low reset
//   bus         spi_fpga_burst_feeder_if.slave (push side + master handshake)
module spi_fpga_burst_feeder #(
  parameter int PACK_LENGTH      = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int LAUNCH_HOLD_CLKS = 5,
  parameter int TIMEOUT_CLKS     = 1024
) (
  input  logic                    IN_CLOCK,
  input  logic                    IN_RESET_N,
  spi_fpga_burst_feeder_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(LAUNCH_HOLD_CLKS + 1);
  localparam int WW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LAUNCH_HOLD_CLKS - 1);
  localparam logic [WW-1:0] WD_ONE    = WW'(1);
  localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT_CLKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_HOLD,
    S_WAIT_DONE,
    S_CAPTURE
  } state_t;

  state_t                 state;
  logic [PACK_LENGTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   full;
  logic                   empty;
  logic                   push_ok;
  logic                   counting;
  logic                   wd_fire;
  logic [HW-1:0]          hold_cnt;
  logic [WW-1:0]          wdog;
  logic                   done_q;
  logic                   launch;
  logic                   busy;
  logic                   timeout;
  logic                   rx_valid;
  logic [PACK_LENGTH-1:0] master_data;
  logic [PACK_LENGTH-1:0] rx_data;

  // Status comes from registered pointers only, so a push is visible one
  // clock later and a same-cycle pop never frees room for a push.
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty    = (wr_ptr == rd_ptr);
  assign push_ok  = bus.IN_PUSH && !full;
  assign counting = (state == S_LAUNCH) || (state == S_HOLD) || (state == S_WAIT_DONE);
  assign wd_fire  = counting && (wdog == WD_LIMIT);

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      wr_ptr <= '0;
    end else if (push_ok) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge IN_CLOCK) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= bus.IN_PUSH_DATA;
    end
  end

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      state       <= S_IDLE;
      rd_ptr      <= '0;
      hold_cnt    <= '0;
      wdog        <= '0;
      done_q      <= 1'b0;
      launch      <= 1'b0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
      rx_valid    <= 1'b0;
      master_data <= '0;
      rx_data     <= '0;
    end else begin
      done_q   <= bus.IN_MASTER_ACTION_DONE;
      rx_valid <= 1'b0;
      if (bus.IN_CLEAR_ERROR) begin
        timeout <= 1'b0;
      end

      if (wd_fire) begin
        // Abort: the popped word is dropped, queued words stay; later
        // assignment to timeout overrides a same-cycle clear.
        timeout <= 1'b1;
        launch  <= 1'b0;
        busy    <= 1'b0;
        state   <= S_IDLE;
      end else begin
        if (counting) begin
          wdog <= wdog + WD_ONE;
        end
        case (state)
          S_IDLE: begin
            if (!empty && !timeout) begin
              master_data <= mem[rd_ptr[AW-1:0]];
              rd_ptr      <= rd_ptr + PTR_ONE;
              wdog        <= '0;
              busy        <= 1'b1;
              state       <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            // Data is already stable for a clock when OUT_LAUNCH rises.
            launch <= 1'b1;
            if (!bus.IN_CS) begin
              hold_cnt <= '0;
              state    <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              launch <= 1'b0;
              state  <= S_WAIT_DONE;
            end else begin
              hold_cnt <= hold_cnt + HOLD_ONE;
            end
          end
          S_WAIT_DONE: begin
            if (bus.IN_MASTER_ACTION_DONE && !done_q) begin
              state <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            rx_data  <= bus.IN_MASTER_RECEIVE_DATA;
            rx_valid <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
          default: begin
            launch <= 1'b0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.OUT_LAUNCH      = launch;
  assign bus.OUT_MASTER_DATA = master_data;
  assign bus.OUT_RX_DATA     = rx_data;
  assign bus.OUT_RX_VALID    = rx_valid;
  assign bus.OUT_FULL        = full;
  assign bus.OUT_EMPTY       = empty;
  assign bus.OUT_BUSY        = busy;
  assign bus.OUT_TIMEOUT     = timeout;

endmodule

// File: tb/tb_spi_fpga_burst_feeder.sv
// tb_spi_fpga_burst_feeder
// Directed bench for spi_fpga_burst_feeder with TIMEOUT_CLKS=16. A small
// SPI master model answers each launch by pulling CS low, waiting for
// OUT_LAUNCH to fall, returning (word ^ 8'hB9) and pulsing done.
module tb_spi_fpga_burst_feeder;
  localparam int PL = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_fpga_burst_feeder_if #(.PACK_LENGTH(PL)) bus ();

  spi_fpga_burst_feeder #(
    .PACK_LENGTH(PL),
    .FIFO_DEPTH(4),
    .LAUNCH_HOLD_CLKS(5),
    .TIMEOUT_CLKS(16)
  ) dut (
    .IN_CLOCK(clk),
    .IN_RESET_N(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       exp_full;
    logic       exp_empty;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t ovf [5];
  vec_t wrap [10];

  int checks = 0;
  int errors = 0;

  logic       resp_en   = 1'b0;
  int         spur_req  = 0;
  int         spur_done = 0;
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  int         rx_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    bus.IN_PUSH      = 1'b1;
    bus.IN_PUSH_DATA = d;
    step();
    bus.IN_PUSH      = 1'b0;
  endtask

  task automatic wait_launch(input string name);
    for (int i = 0; i < 20 && !bus.OUT_LAUNCH; i++) step();
    check(name, 32'(bus.OUT_LAUNCH), 32'd1);
  endtask

  task automatic wait_rx(input int target, input string name);
    for (int i = 0; i < 200 && rx_cnt < target; i++) step();
    check(name, rx_cnt, target);
  endtask

  // Master model
  initial begin
    bus.IN_CS                  = 1'b1;
    bus.IN_MASTER_ACTION_DONE  = 1'b0;
    bus.IN_MASTER_RECEIVE_DATA = '0;
    forever begin
      @(posedge clk);
      #1;
      if (spur_req != spur_done) begin
        bus.IN_MASTER_ACTION_DONE = 1'b1;
        @(posedge clk);
        #1;
        bus.IN_MASTER_ACTION_DONE = 1'b0;
        spur_done++;
      end else if (resp_en && bus.OUT_LAUNCH) begin
        tx_q.push_back(bus.OUT_MASTER_DATA);
        bus.IN_MASTER_RECEIVE_DATA = bus.OUT_MASTER_DATA ^ 8'hB9;
        bus.IN_CS = 1'b0;
        for (int i = 0; i < 40 && bus.OUT_LAUNCH; i++) begin
          @(posedge clk);
          #1;
        end
        bus.IN_CS                 = 1'b1;
        bus.IN_MASTER_ACTION_DONE = 1'b1;
        @(posedge clk);
        #1;
        bus.IN_MASTER_ACTION_DONE = 1'b0;
      end
    end
  end

  // Receive monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.OUT_RX_VALID === 1'b1) begin
      rx_q.push_back(bus.OUT_RX_DATA);
      rx_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int rx_base;
    int tx_base;
    int n;
    int idx;

    ovf[0] = '{8'h01, 1'b0, 1'b0, 8'hB8};
    ovf[1] = '{8'h02, 1'b0, 1'b0, 8'hBB};
    ovf[2] = '{8'h03, 1'b0, 1'b0, 8'hBA};
    ovf[3] = '{8'h04, 1'b1, 1'b0, 8'hBD};
    ovf[4] = '{8'h05, 1'b1, 1'b0, 8'hBC};
    wrap[0] = '{8'h10, 1'b0, 1'b0, 8'hA9};
    wrap[1] = '{8'h11, 1'b0, 1'b0, 8'hA8};
    wrap[2] = '{8'h12, 1'b0, 1'b0, 8'hAB};
    wrap[3] = '{8'h13, 1'b0, 1'b0, 8'hAA};
    wrap[4] = '{8'h14, 1'b0, 1'b0, 8'hAD};
    wrap[5] = '{8'h15, 1'b0, 1'b0, 8'hAC};
    wrap[6] = '{8'h16, 1'b0, 1'b0, 8'hAF};
    wrap[7] = '{8'h17, 1'b0, 1'b0, 8'hAE};
    wrap[8] = '{8'h18, 1'b0, 1'b0, 8'hA1};
    wrap[9] = '{8'h19, 1'b0, 1'b0, 8'hA0};

    bus.IN_PUSH        = 1'b0;
    bus.IN_PUSH_DATA   = '0;
    bus.IN_CLEAR_ERROR = 1'b0;

    // Reset state
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_launch",  32'(bus.OUT_LAUNCH),      32'd0);
    check("rst_empty",   32'(bus.OUT_EMPTY),       32'd1);
    check("rst_full",    32'(bus.OUT_FULL),        32'd0);
    check("rst_busy",    32'(bus.OUT_BUSY),        32'd0);
    check("rst_timeout", 32'(bus.OUT_TIMEOUT),     32'd0);
    check("rst_rxvalid", 32'(bus.OUT_RX_VALID),    32'd0);
    check("rst_rxdata",  32'(bus.OUT_RX_DATA),     32'd0);
    check("rst_mdata",   32'(bus.OUT_MASTER_DATA), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Single word: latency, launch width, capture
    rx_base = rx_cnt;
    tx_base = tx_q.size();
    resp_en = 1'b1;
    push_word(8'hEA);
    check("lat_empty_next", 32'(bus.OUT_EMPTY),  32'd0);
    check("lat_launch_e0",  32'(bus.OUT_LAUNCH), 32'd0);
    step();
    check("lat_launch_e1",  32'(bus.OUT_LAUNCH),      32'd0);
    check("busy_e1",        32'(bus.OUT_BUSY),        32'd1);
    check("mdata_e1",       32'(bus.OUT_MASTER_DATA), 32'hEA);
    step();
    check("lat_launch_e2",  32'(bus.OUT_LAUNCH), 32'd1);
    n = 0;
    for (int i = 0; i < 30 && bus.OUT_LAUNCH; i++) begin
      n++;
      step();
    end
    check("launch_high_cycles", n, 6);
    wait_rx(rx_base + 1, "single_rx_count");
    check("single_rx_data", 32'(rx_q[rx_base]),       32'h53);
    check("single_tx",      32'(tx_q[tx_base]),       32'hEA);
    check("single_mdata",   32'(bus.OUT_MASTER_DATA), 32'hEA);
    repeat (5) step();
    check("single_one_pulse", rx_cnt, rx_base + 1);
    check("single_idle",      32'(bus.OUT_BUSY),  32'd0);
    check("single_empty",     32'(bus.OUT_EMPTY), 32'd1);

    // Spurious done while idle and while in LAUNCH
    rx_base = rx_cnt;
    spur_req++;
    repeat (4) step();
    check("spur_idle_rx",   rx_cnt, rx_base);
    check("spur_idle_busy", 32'(bus.OUT_BUSY), 32'd0);
    resp_en = 1'b0;
    push_word(8'h3C);
    wait_launch("spur_launch");
    spur_req++;
    repeat (4) step();
    check("spur_launch_rx",    rx_cnt, rx_base);
    check("spur_still_launch", 32'(bus.OUT_LAUNCH), 32'd1);
    tx_base = tx_q.size();
    resp_en = 1'b1;
    wait_rx(rx_base + 1, "spur_rx_count");
    check("spur_rx_data", 32'(rx_q[rx_base]), 32'h85);
    check("spur_tx",      32'(tx_q[tx_base]), 32'h3C);
    check("spur_no_to",   32'(bus.OUT_TIMEOUT), 32'd0);

    // Overflow while stalled, watchdog timeout, clear and resume
    resp_en = 1'b0;
    rx_base = rx_cnt;
    tx_base = tx_q.size();
    push_word(8'hC3);
    wait_launch("to_launch");
    for (int i = 1; i <= 16; i++) begin
      if (i <= 5) begin
        bus.IN_PUSH      = 1'b1;
        bus.IN_PUSH_DATA = ovf[i-1].data;
      end
      if (i == 16) bus.IN_CLEAR_ERROR = 1'b1;
      step();
      bus.IN_PUSH = 1'b0;
      if (i <= 5) begin
        check($sformatf("ovf_full_%0d", i),  32'(bus.OUT_FULL),  32'(ovf[i-1].exp_full));
        check($sformatf("ovf_empty_%0d", i), 32'(bus.OUT_EMPTY), 32'(ovf[i-1].exp_empty));
      end
      if (i == 15) begin
        check("to_not_yet",     32'(bus.OUT_TIMEOUT), 32'd0);
        check("to_launch_held", 32'(bus.OUT_LAUNCH),  32'd1);
      end
    end
    bus.IN_CLEAR_ERROR = 1'b0;
    check("to_set_beats_clear", 32'(bus.OUT_TIMEOUT), 32'd1);
    check("to_launch_drop",     32'(bus.OUT_LAUNCH),  32'd0);
    check("to_busy",            32'(bus.OUT_BUSY),    32'd0);
    check("to_queue_full",      32'(bus.OUT_FULL),    32'd1);
    repeat (4) step();
    check("to_hold_launch", 32'(bus.OUT_LAUNCH),  32'd0);
    check("to_hold_full",   32'(bus.OUT_FULL),    32'd1);
    check("to_sticky",      32'(bus.OUT_TIMEOUT), 32'd1);
    check("to_no_rx",       rx_cnt, rx_base);
    resp_en            = 1'b1;
    bus.IN_CLEAR_ERROR = 1'b1;
    step();
    bus.IN_CLEAR_ERROR = 1'b0;
    check("to_cleared", 32'(bus.OUT_TIMEOUT), 32'd0);
    wait_rx(rx_base + 4, "ovf_rx_count");
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ovf_tx_%0d", k), 32'(tx_q[tx_base+k]), 32'(ovf[k].data));
      check($sformatf("ovf_rx_%0d", k), 32'(rx_q[rx_base+k]), 32'(ovf[k].exp_rx));
    end
    repeat (12) step();
    check("ovf_dropped", rx_cnt, rx_base + 4);
    check("ovf_empty_end", 32'(bus.OUT_EMPTY), 32'd1);

    // Wrap-around: 10 words in bursts of 3
    rx_base = rx_cnt;
    tx_base = tx_q.size();
    idx     = 0;
    while (idx < 10) begin
      for (int j = 0; j < 3 && idx < 10; j++) begin
        push_word(wrap[idx].data);
        idx++;
      end
      wait_rx(rx_base + idx, $sformatf("wrap_burst_%0d", idx));
    end
    repeat (3) step();
    check("wrap_count", rx_cnt, rx_base + 10);
    check("wrap_empty", 32'(bus.OUT_EMPTY), 32'd1);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("wrap_tx_%0d", k), 32'(tx_q[tx_base+k]), 32'(wrap[k].data));
      check($sformatf("wrap_rx_%0d", k), 32'(rx_q[rx_base+k]), 32'(wrap[k].exp_rx));
    end

    // Reset during HOLD
    resp_en = 1'b1;
    rx_base = rx_cnt;
    push_word(8'h77);
    push_word(8'h88);
    wait_launch("rst_mid_launch");
    step();
    step();
    check("rst_mid_pre", 32'(bus.OUT_LAUNCH), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_launch_drop", 32'(bus.OUT_LAUNCH),   32'd0);
    check("rst_mid_empty",       32'(bus.OUT_EMPTY),    32'd1);
    check("rst_mid_busy",        32'(bus.OUT_BUSY),     32'd0);
    check("rst_mid_rxvalid",     32'(bus.OUT_RX_VALID), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();
    check("rst_mid_no_rx",      rx_cnt, rx_base);
    check("rst_mid_idle",       32'(bus.OUT_LAUNCH), 32'd0);
    check("rst_mid_empty_post", 32'(bus.OUT_EMPTY),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_fpga_burst_feeder.md
SPI_FPGA_BURST_FEEDER -- requirements
Module: spi_fpga_burst_feeder

Interface
REQ-001 Parameter PACK_LENGTH, default 8, word width; must match the downstream SPI_FPGA_MASTER.
REQ-002 Parameter FIFO_DEPTH, default 4, number of queued transmit words; power of two, at least 2.
REQ-003 Parameter LAUNCH_HOLD_CLKS, default 5, clocks OUT_LAUNCH stays high after CS is seen low.
REQ-004 Parameter TIMEOUT_CLKS, default 1024, per-word watchdog limit in clocks.
REQ-005 IN_CLOCK  in  1  system clock; all logic is on its rising edge.
REQ-006 IN_RESET_N  in  1  reset, asynchronous and active-low.
REQ-007 IN_PUSH  in  1  write strobe; one word per high cycle.
REQ-008 IN_PUSH_DATA  in  PACK_LENGTH  word to enqueue.
REQ-009 IN_CLEAR_ERROR  in  1  clears sticky OUT_TIMEOUT.
REQ-010 IN_CS  in  1  master CS, active-low, same clock domain.
REQ-011 IN_MASTER_ACTION_DONE  in  1  master completion flag.
REQ-012 IN_MASTER_RECEIVE_DATA  in  PACK_LENGTH  word received by master.
REQ-013 OUT_LAUNCH  out  1  launch request to master.
REQ-014 OUT_MASTER_DATA  out  PACK_LENGTH  word presented to master.
REQ-015 OUT_RX_DATA  out  PACK_LENGTH  last captured receive word.
REQ-016 OUT_RX_VALID  out  1  one-cycle pulse when OUT_RX_DATA updates.
REQ-017 OUT_FULL, OUT_EMPTY  out  1 each  FIFO status.
REQ-018 OUT_BUSY  out  1  high in every state except IDLE.
REQ-019 OUT_TIMEOUT  out  1  sticky watchdog error.

Function
REQ-020 FIFO push accepted when IN_PUSH=1 and OUT_FULL=0; push while full is dropped and leaves contents unchanged.
REQ-021 OUT_FULL is evaluated before any same-cycle pop, so push and pop together while full drops the push.
REQ-022 A word pushed into an empty FIFO becomes visible (OUT_EMPTY=0) on the next clock, not the same cycle.
REQ-023 Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full when the low bits are equal and the MSBs differ.
REQ-024 The FSM has states IDLE, LAUNCH, HOLD, WAIT_DONE and CAPTURE.
REQ-025 IDLE: when OUT_EMPTY=0 and OUT_TIMEOUT=0, pop the head into OUT_MASTER_DATA and go to LAUNCH.
REQ-026 OUT_MASTER_DATA stays stable from the pop until the FSM next leaves IDLE.
REQ-027 LAUNCH: OUT_LAUNCH=1; when IN_CS is sampled 0, go to HOLD with the hold counter cleared.
REQ-028 HOLD: OUT_LAUNCH=1 for LAUNCH_HOLD_CLKS clocks, then go to WAIT_DONE with OUT_LAUNCH=0.
REQ-029 WAIT_DONE: on a rising edge of IN_MASTER_ACTION_DONE (current 1, registered previous 0), go to CAPTURE.
REQ-030 Rising edges of IN_MASTER_ACTION_DONE outside WAIT_DONE are ignored.
REQ-031 CAPTURE: register IN_MASTER_RECEIVE_DATA into OUT_RX_DATA, pulse OUT_RX_VALID for exactly one clock, return to IDLE.
REQ-032 Back-to-back words: after CAPTURE, IDLE launches the next word if the FIFO is non-empty; at least one IDLE cycle separates transfers.
REQ-033 Latency: a word pushed while IDLE and empty gives OUT_LAUNCH=1 on the 2nd rising edge after the push edge.
REQ-034 The watchdog counter clears on entry to LAUNCH and counts in LAUNCH, HOLD and WAIT_DONE.
REQ-035 Watchdog at TIMEOUT_CLKS: set OUT_TIMEOUT=1, force OUT_LAUNCH=0, go to IDLE, no OUT_RX_VALID pulse.
REQ-036 On timeout the current word is discarded and the queued words are retained.
REQ-037 While OUT_TIMEOUT=1 no new transfer starts.
REQ-038 IN_CLEAR_ERROR=1 clears OUT_TIMEOUT on the next clock.
REQ-039 If IN_CLEAR_ERROR and a timeout occur in the same cycle, the timeout wins.
REQ-040 Pushes are accepted in every state, including while OUT_TIMEOUT=1.

Reset
REQ-041 IN_RESET_N=0 asynchronously forces state IDLE, empty FIFO, all counters 0.
REQ-042 During reset all outputs are 0 except OUT_EMPTY=1.
REQ-043 Reset mid-transfer drops OUT_LAUNCH immediately, discards the in-flight word, and produces no OUT_RX_VALID.
REQ-044 Reset release is sampled synchronously; the first transfer can start no earlier than the 2nd clock after release.

Verification
REQ-045 Single word: push 8'hEA, master slave returns 8'h53 -> one OUT_LAUNCH high period ending 5 clocks after CS falls, OUT_MASTER_DATA=8'hEA, OUT_RX_DATA=8'h53, one OUT_RX_VALID pulse.
REQ-046 Fill and overflow: push 8'h01..8'h05 with the master stalled (CS held high) -> OUT_FULL=1 after the 4th accepted push, 8'h05 dropped, words transmitted 8'h01..8'h04 in order.
REQ-047 Wrap-around: 10 words pushed in bursts of 3 -> all 10 transmitted in order, 10 OUT_RX_VALID pulses, OUT_EMPTY=1 at the end.
REQ-048 Timeout: CS never falls, TIMEOUT_CLKS=16 -> OUT_TIMEOUT=1 and OUT_LAUNCH=0 16 clocks after launch; next queued word is held until IN_CLEAR_ERROR, then launched.
REQ-049 Reset mid-transfer: assert IN_RESET_N=0 during HOLD -> OUT_LAUNCH=0 with no clock edge, OUT_EMPTY=1, no OUT_RX_VALID after release.
REQ-050 Spurious done: pulse IN_MASTER_ACTION_DONE while IDLE or in LAUNCH -> no capture and no OUT_RX_VALID.
